boot_ctrl: RTL and testbench

Sequences the shared program/data memory between the UART bootloader path and the CPU core. After reset it streams received UART bytes into memory, then releases the CPU. On a scan_memory request it freezes the CPU and dumps memory over the UART transmitter. It sits between the UART rx/tx byte interfaces, the CPU memory port and the single-port synchronous RAM inside the CPU_Bootloader hierarchy.

---
 rtl/boot_ctrl_pkg.sv | 5 +
 rtl/sync_rise.sv | 24 ++
 rtl/boot_ctrl.sv | 88 ++++++++
 tb/tb_boot_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: state encoding and byte width shared by the bootloader sequencer
package boot_ctrl_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_TX} state_t;
endpackage

// File: rtl/sync_rise.sv
// sync_rise: 2-flop synchronizer plus registered rising-edge pulse (clk, rst_n, din -> pulse)
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;
  always_comb begin
    sync_d  = {sync_q[1:0], din};
    pulse_d = sync_q[1] & ~sync_q[2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/boot_ctrl.sv
// boot_ctrl: UART load, CPU run and memory dump sequencer (uart rx/tx bytes, cpu port, ram port, busy)
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              scan_memory,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                scan_pulse, run, last;
  sync_rise u_scan (.clk(clk), .rst_n(rst_n), .din(scan_memory), .pulse(scan_pulse));
  assign run  = state_q == RUN;
  assign last = ptr_q == {ADDR_W{1'b1}};
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    unique case (state_q)
      LOAD: if (rx_valid) begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = last ? RUN : LOAD;
      end
      RUN: if (scan_pulse) begin
        ptr_d   = '0;
        state_d = DUMP_ADDR;
      end
      DUMP_ADDR: state_d = DUMP_WAIT;
      DUMP_WAIT: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
        state_d    = DUMP_TX;
      end
      DUMP_TX: if (tx_ready) begin
        tx_valid_d = 1'b0;
        ptr_d      = ptr_q + ADDR_W'(1);
        state_d    = last ? RUN : DUMP_ADDR;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end
  // Outside RUN the RAM belongs to the sequencer; the pointer addresses both load writes and dump reads.
  assign mem_addr  = run ? cpu_addr : ptr_q;
  assign mem_wdata = run ? cpu_wdata : rx_data;
  assign mem_we    = run ? cpu_we : (state_q == LOAD) & rx_valid;
  assign cpu_rdata = mem_rdata;
  assign cpu_rst   = state_q == LOAD;
  assign cpu_ce    = run & ena;
  assign busy      = ~run;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: scoreboard bench for boot_ctrl load, run mux, dump, backpressure and reset abort
module tb_boot_ctrl;
  localparam int AW = 4;
  localparam int N  = 16;
  logic          clk = 0, rst_n = 0, ena = 1, scan_memory = 0, rx_valid = 0, tx_ready = 0, cpu_we = 0;
  logic [7:0]    rx_data = 0, cpu_wdata = 0, mem_rdata = 0;
  logic [AW-1:0] cpu_addr = 0;
  logic [7:0]    tx_data, cpu_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          tx_valid, cpu_rst, cpu_ce, mem_we, busy;
  logic [7:0]    ram [N];
  logic [7:0]    exp_mem [N];
  logic [AW+7:0] wq [$];
  logic [7:0]    tq [$];
  logic [AW+7:0] mon_w;
  logic [7:0]    mon_t;
  int tests = 0, fails = 0, tx_cnt = 0;
  boot_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .scan_memory(scan_memory),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  always @(negedge clk) if (rst_n) begin
    if (mem_we && cpu_rst) begin
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL load_write unexpected: addr=%0d data=%02h", mem_addr, mem_wdata);
      end else begin
        mon_w = wq.pop_front();
        if ({mem_addr, mem_wdata} !== mon_w) begin
          fails++;
          $display("FAIL load_write: got addr=%0d data=%02h, want addr=%0d data=%02h",
                   mem_addr, mem_wdata, mon_w[AW+7:8], mon_w[7:0]);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      tests++;
      tx_cnt++;
      if (tq.size() == 0) begin
        fails++;
        $display("FAIL tx_byte unexpected: got %02h", tx_data);
      end else begin
        mon_t = tq.pop_front();
        if (tx_data !== mon_t) begin
          fails++;
          $display("FAIL tx_byte: got %02h, want %02h", tx_data, mon_t);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #3 rst_n = 0;
    #1;
    tests++;
    if ({cpu_rst, cpu_ce, mem_we, tx_valid, busy} !== 5'b10001) begin
      fails++;
      $display("FAIL reset_ctrl: got rst/ce/we/txv/busy=%b, want 10001", {cpu_rst, cpu_ce, mem_we, tx_valid, busy});
    end
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_tx_data: got %02h, want 00", tx_data);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask
  task automatic test_load(input logic [7:0] base, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      rx_data = b;
      rx_valid = 1;
      wq.push_back({AW'(i), b});
      exp_mem[i] = b;
      if (i == N - 1) begin
        tests++;
        if (cpu_rst !== 1'b1) begin
          fails++;
          $display("FAIL load_cpu_rst_held: got %b, want 1", cpu_rst);
        end
      end
      step();
      rx_valid = 0;
      if (i % 3 == 1) step();
    end
    if (n == N) begin
      tests++;
      if (wq.size() != 0) begin
        fails++;
        $display("FAIL load_pending: got %0d writes outstanding, want 0", wq.size());
      end
      tests++;
      if ({cpu_rst, cpu_ce, busy} !== 3'b010) begin
        fails++;
        $display("FAIL load_release: got rst/ce/busy=%b, want 010", {cpu_rst, cpu_ce, busy});
      end
    end
  endtask
  task automatic test_run_mux();
    cpu_addr = 5;
    cpu_we = 0;
    step();
    step();
    tests++;
    if (cpu_rdata !== exp_mem[5]) begin
      fails++;
      $display("FAIL run_rdata: got %02h, want %02h", cpu_rdata, exp_mem[5]);
    end
    cpu_we = 1;
    cpu_wdata = 8'hA5;
    #1;
    tests++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(5), 8'hA5}) begin
      fails++;
      $display("FAIL run_mux: got we=%b addr=%0d data=%02h, want we=1 addr=5 data=a5", mem_we, mem_addr, mem_wdata);
    end
    cpu_we = 0;
    rx_data = 8'hFF;
    rx_valid = 1;
    #1;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL run_rx_ignored: got mem_we=%b, want 0", mem_we);
    end
    step();
    rx_valid = 0;
  endtask
  task automatic test_dump(input bit bp);
    int n, cnt;
    bit seen, extra;
    scan_memory = 0;
    tx_ready = 1;
    repeat (4) step();
    for (int i = 0; i < N; i++) tq.push_back(exp_mem[i]);
    tx_cnt = 0;
    scan_memory = 1;
    n = 0;
    while (cpu_ce && n < 8) begin
      step();
      n++;
    end
    tests++;
    if (cpu_ce !== 1'b0 || n > 4) begin
      fails++;
      $display("FAIL dump_freeze: got cpu_ce=%b after %0d cycles, want 0 within 4", cpu_ce, n);
    end
    cnt = 0;
    seen = 0;
    while (busy && cnt < 200) begin
      step();
      cnt++;
      if (bp && !seen && tx_valid && mem_addr == AW'(3)) begin
        seen = 1;
        tx_ready = 0;
        for (int k = 0; k < 10; k++) begin
          step();
          cnt++;
          tests++;
          if ({tx_valid, tx_data, mem_addr} !== {1'b1, exp_mem[3], AW'(3)}) begin
            fails++;
            $display("FAIL bp_hold: got txv=%b data=%02h ptr=%0d, want txv=1 data=%02h ptr=3",
                     tx_valid, tx_data, mem_addr, exp_mem[3]);
          end
        end
        tx_ready = 1;
      end
      scan_memory = bp ? (cnt < 25 || cnt >= 28) : 1'b1;
    end
    tests++;
    if (cnt != (bp ? 58 : 48)) begin
      fails++;
      $display("FAIL dump_cycles: got %0d, want %0d", cnt, bp ? 58 : 48);
    end
    tests++;
    if (tq.size() != 0 || tx_cnt != N) begin
      fails++;
      $display("FAIL dump_count: got %0d bytes sent %0d left, want %0d sent 0 left", tx_cnt, tq.size(), N);
    end
    tests++;
    if ({cpu_ce, cpu_rst, tx_valid} !== {ena, 2'b00}) begin
      fails++;
      $display("FAIL dump_resume: got ce/rst/txv=%b, want %b00", {cpu_ce, cpu_rst, tx_valid}, ena);
    end
    extra = 0;
    repeat (8) begin
      step();
      if (busy) extra = 1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL dump_single: got a second dump, want exactly one");
    end
    tq.delete();
  endtask
  task automatic test_ena();
    ena = 0;
    #1;
    tests++;
    if ({cpu_ce, cpu_rst, busy} !== 3'b000) begin
      fails++;
      $display("FAIL ena_gate: got ce/rst/busy=%b, want 000", {cpu_ce, cpu_rst, busy});
    end
    ena = 1;
    #1;
    tests++;
    if (cpu_ce !== 1'b1) begin
      fails++;
      $display("FAIL ena_restore: got cpu_ce=%b, want 1", cpu_ce);
    end
  endtask
  task automatic test_reset_mid();
    test_reset();
    test_load(8'h20, 7);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({cpu_rst, cpu_ce, busy} !== 3'b101) begin
      fails++;
      $display("FAIL mid_reset: got rst/ce/busy=%b, want 101", {cpu_rst, cpu_ce, busy});
    end
    @(negedge clk);
    rst_n = 1;
    step();
    test_load(8'h20, N);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_load(8'h10, N);
    test_run_mux();
    test_dump(0);
    test_dump(1);
    test_ena();
    test_reset_mid();
    test_dump(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
